// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write path: widths, the write
// request record and the grant encoding used by the write-port arbiter.
package rf_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;

    // One write request for the register file's single write port.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_wr_t;

    // Source that owns the write port in a given cycle.
    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_MDU  = 2'd2
    } grant_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of all non-clock signals around the register-file write arbiter:
// writeback source, MDU result handshake, issue reservation, hazard queries
// and the registered regFile write port.
interface rf_write_arbiter_if
    import rf_pkg::*;
();

    // Pipeline writeback (never stalled, always accepted)
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    // MDU result handshake
    logic              mdu_valid;
    logic              mdu_ready;
    logic [ADDR_W-1:0] mdu_addr;
    logic [DATA_W-1:0] mdu_data;

    // Issue-time reservation of an MDU destination
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;

    // Hazard queries
    logic [ADDR_W-1:0] q1_addr;
    logic [ADDR_W-1:0] q2_addr;
    logic              q1_busy;
    logic              q2_busy;

    // Back-pressure towards the pipeline
    logic              stall_req;

    // regFile write port
    logic [ADDR_W-1:0] rf_a3;
    logic              rf_we3;
    logic [DATA_W-1:0] rf_wd3;

    // Pipeline / MDU / issue side
    modport master (
        output wb_valid, wb_addr, wb_data,
        output mdu_valid, mdu_addr, mdu_data,
        input  mdu_ready,
        output iss_valid, iss_addr,
        output q1_addr, q2_addr,
        input  q1_busy, q2_busy,
        input  stall_req,
        input  rf_a3, rf_we3, rf_wd3
    );

    // Arbiter side
    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  mdu_valid, mdu_addr, mdu_data,
        output mdu_ready,
        input  iss_valid, iss_addr,
        input  q1_addr, q2_addr,
        output q1_busy, q2_busy,
        output stall_req,
        output rf_a3, rf_we3, rf_wd3
    );

endinterface

// File: rtl/rf_wr_fifo.sv
// Small circular FIFO of register write requests buffering MDU results until
// the write port is free. DEPTH must be a power of two and at least 2 so the
// pointers wrap naturally.
module rf_wr_fifo
    import rf_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  rf_wr_t           push_data,
    input  logic             pop,
    output rf_wr_t           head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    rf_wr_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Ignore requests that would overflow or underflow.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage write.
    // NOTE: the data array has no reset; only pointers and count define
    // which entries are valid, so clearing the storage would buy nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Single write-port arbiter for the register file. The pipeline writeback has
// absolute priority; MDU results wait in a small FIFO and drain whenever the
// writeback slot is empty. A scoreboard marks registers with MDU results still
// in flight, and a starvation counter asks the pipeline for a bubble when a
// buffered MDU result has been blocked too long or the buffer is full.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_LIM = 4
) (
    input logic                clk,
    input logic                rst_n,
    rf_write_arbiter_if.slave  bus
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SCNT_W = $clog2(STARVE_LIM + 1);

    // FIFO connections
    logic             fifo_push;
    logic             fifo_pop;
    rf_wr_t           fifo_in;
    rf_wr_t           fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    // Arbitration result
    grant_e           grant;
    rf_wr_t           win;

    // Scoreboard and starvation tracking
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_next;
    logic [SCNT_W-1:0] starve_cnt;

    // Registered write port
    logic [ADDR_W-1:0] rf_a3_q;
    logic              rf_we3_q;
    logic [DATA_W-1:0] rf_wd3_q;

    assign fifo_in.addr  = bus.mdu_addr;
    assign fifo_in.data  = bus.mdu_data;
    assign bus.mdu_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign fifo_push     = bus.mdu_valid && bus.mdu_ready;
    assign fifo_pop      = (grant == GNT_MDU);

    rf_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Pick the single owner of the write port: writeback, else FIFO head.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        grant = GNT_IDLE;
        win   = '0;
        if (bus.wb_valid) begin
            grant    = GNT_WB;
            win.addr = bus.wb_addr;
            win.data = bus.wb_data;
        end else if (!fifo_empty) begin
            grant = GNT_MDU;
            win   = fifo_head;
        end
    end

    // Register the winner onto the regFile port; r0 writes are swallowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_a3_q  <= '0;
            rf_we3_q <= 1'b0;
            rf_wd3_q <= '0;
        end else begin
            rf_we3_q <= (grant != GNT_IDLE) && (win.addr != '0);
            if (grant != GNT_IDLE) begin
                rf_a3_q  <= win.addr;
                rf_wd3_q <= win.data;
            end
        end
    end

    assign bus.rf_a3  = rf_a3_q;
    assign bus.rf_we3 = rf_we3_q;
    assign bus.rf_wd3 = rf_wd3_q;

    // Scoreboard update: clear on pop, then set on issue so a same-address
    // set wins; r0 is never marked.
    always_comb begin
        busy_next = busy;
        if (fifo_pop) begin
            busy_next[fifo_head.addr] = 1'b0;
        end
        if (bus.iss_valid) begin
            busy_next[bus.iss_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Hazard queries read the registered scoreboard only (no same-cycle bypass).
    assign bus.q1_busy = busy[bus.q1_addr];
    assign bus.q2_busy = busy[bus.q2_addr];

    // Count cycles a buffered MDU result is held off by writeback, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (fifo_empty || fifo_pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SCNT_W'(STARVE_LIM)) begin
            starve_cnt <= starve_cnt + SCNT_W'(1);
        end
    end

    assign bus.stall_req = (starve_cnt == SCNT_W'(STARVE_LIM)) || fifo_full;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: a directed vector table with
// hand-derived expectations, a hand-written reset-in-flight sequence, and
// random traffic checked against a queue-based reference model.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIM   = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .STARVE_LIM (LIM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        iv;
        logic [4:0]  ia;
        logic [4:0]  q1;
        logic [4:0]  q2;
        bit          has_exp;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic        e_rdy;
        logic        e_stl;
        logic        e_b1;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    rf_wr_t      mq[$];
    bit          m_busy[NREG];
    int          m_starve;
    bit          m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t V(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                               input logic mv, input logic [4:0] ma, input logic [31:0] md,
                               input logic iv, input logic [4:0] ia, input logic [4:0] q1,
                               input logic e_we, input logic [4:0] e_a3, input logic [31:0] e_wd,
                               input logic e_rdy, input logic e_stl, input logic e_b1);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd;
        v.mv = mv; v.ma = ma; v.md = md;
        v.iv = iv; v.ia = ia; v.q1 = q1; v.q2 = 5'd0;
        v.has_exp = 1'b1;
        v.e_we = e_we; v.e_a3 = e_a3; v.e_wd = e_wd;
        v.e_rdy = e_rdy; v.e_stl = e_stl; v.e_b1 = e_b1;
        return v;
    endfunction

    function automatic vec_t idle(input logic [4:0] q1);
        vec_t v;
        v = V(0, 0, 0, 0, 0, 0, 0, 0, q1, 0, 0, 0, 0, 0, 0);
        v.has_exp = 1'b0;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.wb_valid  = v.wv;
        bus.wb_addr   = v.wa;
        bus.wb_data   = v.wd;
        bus.mdu_valid = v.mv;
        bus.mdu_addr  = v.ma;
        bus.mdu_data  = v.md;
        bus.iss_valid = v.iv;
        bus.iss_addr  = v.ia;
        bus.q1_addr   = v.q1;
        bus.q2_addr   = v.q2;
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        m_starve = 0;
        m_we     = 1'b0;
        m_a3     = '0;
        m_wd     = '0;
    endtask

    // One clock cycle: drive at the falling edge, compare, advance the model.
    task automatic run_cycle(input vec_t v);
        bit     ready;
        bit     stall;
        bit     pop;
        bit     push;
        bit     was_empty;
        rf_wr_t hd;
        rf_wr_t nw;
        @(negedge clk);
        drive(v);
        #1;
        ready = (mq.size() < DEPTH);
        stall = (m_starve == LIM) || (mq.size() == DEPTH);
        check("mdu_ready", bus.mdu_ready, ready);
        check("stall_req", bus.stall_req, stall);
        check("q1_busy", bus.q1_busy, m_busy[v.q1]);
        check("q2_busy", bus.q2_busy, m_busy[v.q2]);
        check("rf_we3", bus.rf_we3, m_we);
        if (m_we) begin
            check("rf_a3", bus.rf_a3, m_a3);
            check("rf_wd3", bus.rf_wd3, m_wd);
        end
        if (v.has_exp) begin
            check("tbl_we3", bus.rf_we3, v.e_we);
            if (v.e_we) begin
                check("tbl_a3", bus.rf_a3, v.e_a3);
                check("tbl_wd3", bus.rf_wd3, v.e_wd);
            end
            check("tbl_ready", bus.mdu_ready, v.e_rdy);
            check("tbl_stall", bus.stall_req, v.e_stl);
            check("tbl_q1_busy", bus.q1_busy, v.e_b1);
        end
        // Advance the reference model across the coming rising edge.
        was_empty = (mq.size() == 0);
        pop  = !v.wv && !was_empty;
        push = v.mv && ready;
        m_we = 1'b0;
        if (v.wv) begin
            m_we = (v.wa != 0);
            m_a3 = v.wa;
            m_wd = v.wd;
        end else if (pop) begin
            hd   = mq.pop_front();
            m_we = (hd.addr != 0);
            m_a3 = hd.addr;
            m_wd = hd.data;
            m_busy[hd.addr] = 1'b0;
        end
        if (v.iv && v.ia != 0) m_busy[v.ia] = 1'b1;
        if (push) begin
            nw.addr = v.ma;
            nw.data = v.md;
            mq.push_back(nw);
        end
        if (was_empty || pop) m_starve = 0;
        else if (m_starve < LIM) m_starve++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t r;

        // Reset state
        rst_n = 1'b0;
        drive(idle(0));
        model_reset();
        #12;
        check("rst_we3", bus.rf_we3, 1'b0);
        check("rst_a3", bus.rf_a3, 5'd0);
        check("rst_wd3", bus.rf_wd3, 32'd0);
        check("rst_ready", bus.mdu_ready, 1'b1);
        check("rst_stall", bus.stall_req, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: inputs this cycle, outputs observed this cycle.
        //         wv wa  wd     mv ma  md    iv ia  q1   we a3  wd     rdy stl b1
        tbl.push_back(V(1, 5, 18,    0, 0, 0,    0, 0, 0,   0, 0, 0,     1, 0, 0)); // plain writeback
        tbl.push_back(V(0, 0, 0,     0, 0, 0,    0, 0, 5,   1, 5, 18,    1, 0, 0));
        tbl.push_back(V(0, 0, 0,     0, 0, 0,    1, 7, 7,   0, 0, 0,     1, 0, 0)); // reserve r7, no bypass
        tbl.push_back(V(0, 0, 0,     0, 0, 0,    0, 0, 7,   0, 0, 0,     1, 0, 1));
        tbl.push_back(V(0, 0, 0,     1, 7, 9,    0, 0, 7,   0, 0, 0,     1, 0, 1)); // MDU push
        tbl.push_back(V(0, 0, 0,     0, 0, 0,    0, 0, 7,   0, 0, 0,     1, 0, 1)); // pop
        tbl.push_back(V(0, 0, 0,     0, 0, 0,    0, 0, 7,   1, 7, 9,     1, 0, 0));
        tbl.push_back(V(1, 1, 'h11,  1, 10, 100, 0, 0, 0,   0, 0, 0,     1, 0, 0)); // starvation
        tbl.push_back(V(1, 2, 'h12,  0, 0, 0,    0, 0, 0,   1, 1, 'h11,  1, 0, 0));
        tbl.push_back(V(1, 3, 'h13,  0, 0, 0,    0, 0, 0,   1, 2, 'h12,  1, 0, 0));
        tbl.push_back(V(1, 4, 'h14,  0, 0, 0,    0, 0, 0,   1, 3, 'h13,  1, 0, 0));
        tbl.push_back(V(1, 5, 'h15,  0, 0, 0,    0, 0, 0,   1, 4, 'h14,  1, 0, 0));
        tbl.push_back(V(1, 6, 'h16,  0, 0, 0,    0, 0, 0,   1, 5, 'h15,  1, 1, 0));
        tbl.push_back(V(0, 0, 0,     0, 0, 0,    0, 0, 0,   1, 6, 'h16,  1, 1, 0));
        tbl.push_back(V(0, 0, 0,     0, 0, 0,    0, 0, 0,   1, 10, 100,  1, 0, 0));
        tbl.push_back(V(1, 1, 'h21,  1, 11, 111, 0, 0, 0,   0, 0, 0,     1, 0, 0)); // FIFO full
        tbl.push_back(V(1, 2, 'h22,  1, 12, 112, 0, 0, 0,   1, 1, 'h21,  1, 0, 0));
        tbl.push_back(V(1, 3, 'h23,  1, 13, 113, 0, 0, 0,   1, 2, 'h22,  0, 1, 0));
        tbl.push_back(V(0, 0, 0,     1, 13, 113, 0, 0, 0,   1, 3, 'h23,  0, 1, 0));
        tbl.push_back(V(0, 0, 0,     1, 13, 113, 0, 0, 0,   1, 11, 111,  1, 0, 0)); // push+pop
        tbl.push_back(V(0, 0, 0,     0, 0, 0,    0, 0, 0,   1, 12, 112,  1, 0, 0));
        tbl.push_back(V(0, 0, 0,     0, 0, 0,    0, 0, 0,   1, 13, 113,  1, 0, 0));
        tbl.push_back(V(0, 0, 0,     0, 0, 0,    0, 0, 0,   0, 0, 0,     1, 0, 0));
        tbl.push_back(V(1, 0, 18,    1, 0, 55,   1, 0, 0,   0, 0, 0,     1, 0, 0)); // r0 writes
        tbl.push_back(V(0, 0, 0,     0, 0, 0,    0, 0, 0,   0, 0, 0,     1, 0, 0));
        tbl.push_back(V(0, 0, 0,     0, 0, 0,    0, 0, 0,   0, 0, 0,     1, 0, 0));
        tbl.push_back(V(0, 0, 0,     0, 0, 0,    0, 0, 0,   0, 0, 0,     1, 0, 0));
        foreach (tbl[i]) run_cycle(tbl[i]);

        // Reset with two buffered MDU results and r3 reserved.
        r = idle(0); r.iv = 1'b1; r.ia = 5'd3;
        run_cycle(r);
        r = idle(0); r.wv = 1'b1; r.wa = 5'd1; r.wd = 32'h1; r.mv = 1'b1; r.ma = 5'd20; r.md = 32'd200;
        run_cycle(r);
        r = idle(0); r.wv = 1'b1; r.wa = 5'd2; r.wd = 32'h2; r.mv = 1'b1; r.ma = 5'd21; r.md = 32'd201;
        run_cycle(r);
        @(negedge clk);
        drive(idle(3));
        #1;
        check("pre_rst_q1_busy", bus.q1_busy, 1'b1);
        check("pre_rst_ready", bus.mdu_ready, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we3", bus.rf_we3, 1'b0);
        check("mid_rst_a3", bus.rf_a3, 5'd0);
        check("mid_rst_wd3", bus.rf_wd3, 32'd0);
        check("mid_rst_ready", bus.mdu_ready, 1'b1);
        check("mid_rst_stall", bus.stall_req, 1'b0);
        check("mid_rst_q1_busy", bus.q1_busy, 1'b0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r = V(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0, 0);
            run_cycle(r);
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            r = idle(0);
            r.wv = ($urandom_range(0, 9) < 6);
            r.wa = 5'($urandom_range(0, 7));
            r.wd = $urandom;
            r.mv = ($urandom_range(0, 9) < 5);
            r.ma = 5'($urandom_range(0, 7));
            r.md = $urandom;
            r.iv = ($urandom_range(0, 9) < 3);
            r.ia = 5'($urandom_range(0, 7));
            r.q1 = 5'($urandom_range(0, 7));
            r.q2 = 5'($urandom_range(0, 31));
            run_cycle(r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
